// File: rtl/multi_queue_if.sv
// Handshake bundle for multi_queue: producer side (start/in/delay) and
// consumer side (done/out/out_ready) plus status outputs.
interface multi_queue_if #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int DELAY_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               start;
  logic [WIDTH-1:0]   in;
  logic [DELAY_W-1:0] delay;
  logic               ready;
  logic               done;
  logic [WIDTH-1:0]   out;
  logic               out_ready;
  logic [CNT_W-1:0]   count;
  logic               dropped;

  modport master (
    output start, in, delay, out_ready,
    input  ready, done, out, count, dropped
  );

  modport slave (
    input  start, in, delay, out_ready,
    output ready, done, out, count, dropped
  );
endinterface

// File: rtl/multi_queue.sv
// In-order delay queue: each accepted payload completes once it has spent
// its own delay cycles at the head; completions are held until consumed.
module multi_queue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int DELAY_W = 4
) (
  input logic          clock,
  input logic          reset_n,
  multi_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem_data  [DEPTH];
  logic [DELAY_W-1:0] mem_delay [DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [DELAY_W-1:0] head_cnt;
  logic               dropped_q;

  logic               not_empty;
  logic               ready_int;
  logic               done_int;
  logic               accept;
  logic               pop;
  logic [DELAY_W-1:0] head_delay;

  assign not_empty  = (count_q != '0);
  assign ready_int  = (count_q < CNT_W'(DEPTH));
  assign head_delay = mem_delay[rd_ptr];
  assign done_int   = not_empty && (head_cnt == head_delay);
  assign accept     = bus.start && ready_int;
  assign pop        = done_int && bus.out_ready;

  assign bus.ready   = ready_int;
  assign bus.done    = done_int;
  assign bus.out     = done_int ? mem_data[rd_ptr] : '0;
  assign bus.count   = count_q;
  assign bus.dropped = dropped_q;

  // Payload storage is left unreset; done gates every read of it.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_data[wr_ptr]  <= bus.in;
      mem_delay[wr_ptr] <= bus.delay;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= bus.start && !ready_int;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head age saturates at the head delay so a stalled completion stays put.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_cnt <= '0;
    end else if (pop) begin
      head_cnt <= '0;
    end else if (not_empty && (head_cnt < head_delay)) begin
      head_cnt <= head_cnt + DELAY_W'(1);
    end
  end
endmodule

// File: tb/tb_multi_queue.sv
// Self-checking bench for multi_queue: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_multi_queue;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int DELAY_W = 4;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  multi_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_W(DELAY_W)) bus ();

  multi_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_W(DELAY_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: entries wait in order; the head completes once it has
  // been head for at least its delay cycles.
  typedef struct {
    logic [31:0] data;
    int          dly;
  } ent_t;

  ent_t q[$];
  int   age;
  logic exp_drop;

  function automatic void model_reset();
    q.delete();
    age      = 0;
    exp_drop = 1'b0;
  endfunction

  function automatic logic model_done();
    return (q.size() > 0) && (age >= q[0].dly);
  endfunction

  function automatic logic [37:0] expv();
    logic d;
    d = model_done();
    return {d, (d ? q[0].data : 32'h0), 3'(q.size()), (q.size() < DEPTH), exp_drop};
  endfunction

  function automatic void model_edge(input logic s, input logic [31:0] d, input int dl, input logic ordy);
    logic pop_m;
    logic acc_m;
    ent_t e;
    pop_m    = model_done() && ordy;
    acc_m    = s && (q.size() < DEPTH);
    exp_drop = s && !(q.size() < DEPTH);
    if (pop_m) begin
      void'(q.pop_front());
      age = 0;
    end else if (q.size() > 0) begin
      age++;
    end
    if (acc_m) begin
      e.data = d;
      e.dly  = dl;
      q.push_back(e);
    end
  endfunction

  function automatic logic [37:0] dutv();
    return {bus.done, bus.out, bus.count, bus.ready, bus.dropped};
  endfunction

  task automatic step(input logic s, input logic [31:0] d, input int dl, input logic ordy);
    bus.start     = s;
    bus.in        = d;
    bus.delay     = DELAY_W'(dl);
    bus.out_ready = ordy;
    @(posedge clock);
    model_edge(s, d, dl & 15, ordy);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (dutv() !== expv()) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dutv(), expv());
    end
    checks++;
    if ({bus.done, bus.out, bus.count, bus.ready} !== {1'b0, 32'h0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: done=%b out=%h count=%0d ready=%b", bus.done, bus.out, bus.count, bus.ready);
    end
  endtask

  task automatic test_single();
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) step(1'b1, 32'hDEADBEEF, 3, 1'b1);
      else        step(1'b0, 32'h0, 0, 1'b1);
      checks++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL single_model k=%0d: got %h expected %h", k, dutv(), expv());
      end
      checks++;
      if ({bus.done, bus.out} !== ((k == 4) ? {1'b1, 32'hDEADBEEF} : {1'b0, 32'h0})) begin
        errors++;
        $display("FAIL single_latency k=%0d: done=%b out=%h", k, bus.done, bus.out);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 6; k++) begin
      step(k <= 4, 32'(k), 0, 1'b1);
      checks++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL b2b_model k=%0d: got %h expected %h", k, dutv(), expv());
      end
      checks++;
      if ({bus.done, bus.out} !== ((k <= 4) ? {1'b1, 32'(k)} : {1'b0, 32'h0})) begin
        errors++;
        $display("FAIL b2b_sequence k=%0d: done=%b out=%h", k, bus.done, bus.out);
      end
    end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 6; k++) begin
      step(k <= 5, 32'hA0 + 32'(k), 7, 1'b0);
      checks++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL full_model k=%0d: got %h expected %h", k, dutv(), expv());
      end
      if (k >= 4) begin
        checks++;
        if ({bus.ready, bus.count, bus.dropped} !== {1'b0, 3'd4, (k == 5)}) begin
          errors++;
          $display("FAIL full_status k=%0d: ready=%b count=%0d dropped=%b", k, bus.ready, bus.count, bus.dropped);
        end
      end
    end
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 32'h0, 0, 1'b1);
      checks++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL full_drain k=%0d: got %h expected %h", k, dutv(), expv());
      end
    end
    checks++;
    if (bus.count !== 3'd0) begin
      errors++;
      $display("FAIL full_empty: count=%0d expected 0", bus.count);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 1; k <= 8; k++) begin
      step(k == 1, 32'h55, 1, k == 8);
      checks++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL bp_model k=%0d: got %h expected %h", k, dutv(), expv());
      end
      if (k >= 2) begin
        checks++;
        if ({bus.done, bus.out, bus.count} !== ((k <= 7) ? {1'b1, 32'h55, 3'd1} : {1'b0, 32'h0, 3'd0})) begin
          errors++;
          $display("FAIL bp_hold k=%0d: done=%b out=%h count=%0d", k, bus.done, bus.out, bus.count);
        end
      end
    end
  endtask

  task automatic test_ordering();
    int t1;
    int t2;
    t1 = -1;
    t2 = -1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1)      step(1'b1, 32'h11, 5, 1'b1);
      else if (k == 2) step(1'b1, 32'h22, 0, 1'b1);
      else             step(1'b0, 32'h0, 0, 1'b1);
      checks++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL order_model k=%0d: got %h expected %h", k, dutv(), expv());
      end
      if (bus.done === 1'b1 && bus.out === 32'h11 && t1 < 0) t1 = k;
      if (bus.done === 1'b1 && bus.out === 32'h22 && t2 < 0) t2 = k;
    end
    checks++;
    if (t1 != 6 || t2 != t1 + 1) begin
      errors++;
      $display("FAIL order_timing: first done k=%0d (want 6), second k=%0d (want 7)", t1, t2);
    end
  endtask

  task automatic test_random();
    logic s;
    logic o;
    int   dl;
    for (int k = 0; k < 400; k++) begin
      s  = ($urandom % 2) == 0;
      o  = ($urandom % 4) != 0;
      dl = (($urandom % 8) == 0) ? int'($urandom % 16) : int'($urandom % 3);
      step(s, $urandom, dl, o);
      checks++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL random_model k=%0d: got %h expected %h", k, dutv(), expv());
      end
    end
    for (int k = 0; k < 80; k++) begin
      step(1'b0, 32'h0, 0, 1'b1);
      checks++;
      if (dutv() !== expv()) begin
        errors++;
        $display("FAIL random_drain k=%0d: got %h expected %h", k, dutv(), expv());
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 1; k <= 3; k++) step(1'b1, 32'hC0 + 32'(k), 9, 1'b1);
    step(1'b0, 32'h0, 0, 1'b1);
    checks++;
    if (bus.count !== 3'd3) begin
      errors++;
      $display("FAIL midflight_fill: count=%0d expected 3", bus.count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.done, bus.out, bus.count, bus.ready, bus.dropped} !== {1'b0, 32'h0, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midflight_async: done=%b out=%h count=%0d ready=%b dropped=%b",
               bus.done, bus.out, bus.count, bus.ready, bus.dropped);
    end
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 32'h0, 0, 1'b1);
      checks++;
      if (dutv() !== expv() || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL midflight_after k=%0d: got %h expected %h", k, dutv(), expv());
      end
    end
    step(1'b1, 32'h77, 0, 1'b1);
    checks++;
    if ({bus.done, bus.out} !== {1'b1, 32'h77}) begin
      errors++;
      $display("FAIL midflight_restart: done=%b out=%h", bus.done, bus.out);
    end
    step(1'b0, 32'h0, 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.in        = '0;
    bus.delay     = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #12;
    reset_n = 1'b1;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_backpressure();
    test_ordering();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_queue.md
MULTI_QUEUE -- requirements
Module: multi_queue

Interface
REQ-001 Parameter WIDTH, default 32, data width of in/out.
REQ-002 Parameter DEPTH, default 4, maximum outstanding transactions; power of two, 2..16.
REQ-003 Parameter DELAY_W, default 4, width of per-transaction delay field.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to enqueue a transaction this cycle.
REQ-007 in  input  WIDTH  transaction payload, sampled with start.
REQ-008 delay  input  DELAY_W  per-transaction latency, sampled with start.
REQ-009 ready  output  1  queue can accept a transaction this cycle.
REQ-010 done  output  1  head transaction complete; out valid.
REQ-011 out  output  WIDTH  head payload when done, else all zeros.
REQ-012 out_ready  input  1  consumer accepts completed transaction.
REQ-013 count  output  $clog2(DEPTH)+1  number of queued transactions.
REQ-014 dropped  output  1  one-cycle pulse: start seen while not ready.

Function
REQ-015 Transaction accepted at a rising edge where start=1 and ready=1; {in, delay} written to FIFO tail.
REQ-016 ready SHALL equal (count < DEPTH), combinational from registered count; no push-through when full, even if a pop occurs in the same cycle.
REQ-017 start=1 with ready=0: transaction discarded, FIFO unchanged, dropped=1 in the following cycle only.
REQ-018 Head counter (DELAY_W bits) SHALL be 0 in the first cycle an entry occupies the head and increment by 1 each cycle while below head delay.
REQ-019 done SHALL be 1 whenever count>0 and head counter == head delay; done is combinational from registered state.
REQ-020 out SHALL equal head payload while done=1, else 0.
REQ-021 Pop at a rising edge where done=1 and out_ready=1; the next entry, if any, becomes head with counter 0 in the next cycle.
REQ-022 done=1 with out_ready=0: done, out, and counter held (counter saturates at delay) until out_ready=1.
REQ-023 Latency: transaction accepted into empty queue at edge t with delay d, out_ready=1, yields done high exactly in cycle t+1+d for one cycle.
REQ-024 delay=0 entries with out_ready=1 SHALL complete back-to-back, one per cycle.
REQ-025 Completion strictly in acceptance order; a short-delay entry waits behind a longer head.
REQ-026 Simultaneous accept and pop: count unchanged; both operations take effect.
REQ-027 Accept into empty queue: entry becomes head next cycle; done never asserted in the accept cycle.
REQ-028 FIFO read/write pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-029 Counter never wraps; compare and increment are DELAY_W bits unsigned.

Reset
REQ-030 reset_n=0 SHALL immediately (asynchronously) clear count, pointers, head counter, dropped; thus done=0, out=0, ready=1.
REQ-031 Reset mid-operation discards all queued transactions; no done pulse for them after release.
REQ-032 FIFO payload storage need not be reset.
REQ-033 First accept possible at the first rising edge after reset_n deasserts.

Verification
REQ-034 Single: reset, start=1 in=0xDEADBEEF delay=3 at edge 0, out_ready=1 -> done=1, out=0xDEADBEEF in cycle 4 only; out=0 elsewhere.
REQ-035 Back-to-back: 4 starts, delay=0, payloads 1..4, out_ready=1 -> done high 4 consecutive cycles, out 1,2,3,4.
REQ-036 Full: DEPTH=4, 5 consecutive starts, delay=7 -> ready=0 after 4th, 5th dropped, dropped pulse 1 cycle, count=4.
REQ-037 Backpressure: delay=1, out_ready=0 for 5 cycles after done -> done/out held stable, pop on first out_ready=1 cycle, count decrements.
REQ-038 Ordering: delays 5 then 0 -> second completes exactly 1 cycle after first pops.
REQ-039 Reset mid-flight: 3 queued, reset_n=0 between edges -> done=0, count=0, ready=1 immediately; no completion after release.
